// File: rtl/buffer_seq_ctrl_pkg.sv
// Shared definitions for the buffer sequencer and the Buffer it drives.
//   state_t        : controller state encoding (2-bit)
//   DEF_LENGTH_SIZE: default words per fill/pass, shared with Buffer instances
//   DEF_ADR_SIZE   : default address width, shared with Buffer instances
//   DEF_PASS_SIZE  : default width of the drain pass count
package buffer_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_LENGTH_SIZE = 10;
  localparam int unsigned DEF_ADR_SIZE    = 4;
  localparam int unsigned DEF_PASS_SIZE   = 8;

endpackage

// File: rtl/buffer_seq_ctrl_wrap_counter.sv
// Up-counter that wraps to zero after reaching MAX.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : advance by one, wrapping MAX -> 0
//   cnt      : current count
//   tc       : terminal count, cnt == MAX
module wrap_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == WIDTH'(MAX));

  // Wrap is explicit at MAX so a non-power-of-two length never runs past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= tc ? '0 : cnt + WIDTH'(1);
  end

endmodule

// File: rtl/buffer_seq_ctrl.sv
// Sequencer for one single-port Buffer: fills it from a valid/ready producer,
// then replays it drainPasses times to a valid/ready consumer. Data bypasses
// this block; only address/write-enable and handshakes are generated here.
//   clk, rst    : clock, async active-high reset
//   start       : job request, sampled only in IDLE
//   drainPasses : number of replay passes, latched on accepted start
//   inValid/inReady   : producer handshake (FILL)
//   outValid/outReady : consumer handshake (DRAIN), outLast marks end of pass
//   bufWr, bufAdr     : Buffer write enable and address
//   busy        : not in IDLE
//   done        : one-cycle completion pulse
//
// state   | meaning
// S_IDLE  | waiting for start, all handshakes low
// S_FILL  | accepting producer words at adr 0..LENGTH_SIZE-1
// S_DRAIN | replaying buffer to consumer, pass by pass
// S_DONE  | one-cycle done pulse, then back to IDLE
module buffer_seq_ctrl
  import buffer_seq_ctrl_pkg::*;
#(
  parameter int unsigned LENGTH_SIZE = DEF_LENGTH_SIZE,
  parameter int unsigned ADR_SIZE    = DEF_ADR_SIZE,
  parameter int unsigned PASS_SIZE   = DEF_PASS_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PASS_SIZE-1:0] drainPasses,
  input  logic                 inValid,
  output logic                 inReady,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 outLast,
  output logic                 bufWr,
  output logic [ADR_SIZE-1:0]  bufAdr,
  output logic                 busy,
  output logic                 done
);

  state_t state, state_nxt;

  logic [ADR_SIZE-1:0]  adrCnt;
  logic                 adr_tc;
  logic                 adr_en;
  logic                 adr_clr;
  logic                 fill_step;
  logic                 drain_step;

  logic [PASS_SIZE-1:0] passCnt;
  logic [PASS_SIZE-1:0] passesReg;
  logic                 last_pass;

  assign fill_step  = (state == S_FILL)  && inValid;
  assign drain_step = (state == S_DRAIN) && outReady;
  assign adr_en     = fill_step || drain_step;
  assign adr_clr    = (state == S_IDLE) || (state == S_DONE);

  wrap_counter #(
    .WIDTH (ADR_SIZE),
    .MAX   (LENGTH_SIZE - 1)
  ) u_adr_cnt (
    .clk (clk),
    .rst (rst),
    .clr (adr_clr),
    .en  (adr_en),
    .cnt (adrCnt),
    .tc  (adr_tc)
  );

  // passesReg-1 is only meaningful when passesReg != 0; the zero case
  // bypasses DRAIN entirely, so it is masked here rather than underflowing.
  always_comb begin
    last_pass = 1'b0;
    if (passesReg != '0)
      last_pass = (passCnt == (passesReg - PASS_SIZE'(1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      passesReg <= '0;
      passCnt   <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        passesReg <= drainPasses;
        passCnt   <= '0;
      end
      if (drain_step && adr_tc)
        passCnt <= last_pass ? '0 : passCnt + PASS_SIZE'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FILL;
      S_FILL:  if (fill_step && adr_tc)
                 state_nxt = (passesReg == '0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (drain_step && adr_tc && last_pass) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    inReady  = 1'b0;
    outValid = 1'b0;
    outLast  = 1'b0;
    bufWr    = 1'b0;
    bufAdr   = '0;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    case (state)
      S_FILL: begin
        inReady = 1'b1;
        bufWr   = inValid;
        bufAdr  = adrCnt;
      end
      S_DRAIN: begin
        outValid = 1'b1;
        outLast  = adr_tc;
        bufAdr   = adrCnt;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
